// File: rtl/debug_pkg.sv
// Shared definitions for the debug readback unit.
//   N_WORDS / TBL_SEL_W : size and code width of the latch select table
//   SYNC                : frame sync byte sent ahead of word 0
//   dump_state_t        : latch dump sequencer FSM states
//   sel_lookup()        : table index -> debug mux select code
package debug_pkg;

  localparam int         N_WORDS   = 19;
  localparam int         TBL_SEL_W = 7;
  localparam logic [7:0] SYNC      = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC_TX = 3'd1,
    ST_SEL     = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CAP     = 3'd4,
    ST_SEND    = 3'd5,
    ST_DONE    = 3'd6
  } dump_state_t;

  // Code 22 has no latch behind it, so it is deliberately absent.
  function automatic logic [TBL_SEL_W-1:0] sel_lookup(input int unsigned idx);
    logic [TBL_SEL_W-1:0] code;
    case (idx)
      0:  code = 7'h00;  1:  code = 7'h01;
      2:  code = 7'h10;  3:  code = 7'h11;  4:  code = 7'h12;
      5:  code = 7'h13;  6:  code = 7'h14;  7:  code = 7'h15;
      8:  code = 7'h20;  9:  code = 7'h21;  10: code = 7'h23;
      11: code = 7'h24;  12: code = 7'h25;
      13: code = 7'h30;  14: code = 7'h31;  15: code = 7'h32;
      16: code = 7'h33;
      17: code = 7'h40;  18: code = 7'h41;
      default: code = '0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/word_serializer.sv
// Serialises one DATA_W word into bytes, LSB byte first, over a valid/ready
// byte interface.
//   i_load / i_load_data : capture a new word (only while idle)
//   o_byte / o_valid     : current byte and its valid flag
//   i_ready              : consumer accepts the byte when o_valid && i_ready
//   o_word_done          : pulses with the handshake of the last byte
// Handshake: once o_valid is high, o_valid and o_byte stay unchanged until a
// cycle with i_ready=1; i_ready while o_valid=0 has no effect. Bytes of one
// word go back to back because the next byte is already in the shift register.
module word_serializer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_ready,
  output logic [7:0]        o_byte,
  output logic              o_valid,
  output logic              o_word_done
);

  localparam int N_BYTES = DATA_W / 8;
  localparam int CNT_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

  logic [DATA_W-1:0] r_shreg;
  logic [CNT_W-1:0]  r_byte_cnt;
  logic              r_valid;
  logic              w_fire;
  logic              w_last;

  assign w_fire = r_valid & i_ready;
  assign w_last = (r_byte_cnt == CNT_W'(N_BYTES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg    <= '0;
      r_byte_cnt <= '0;
      r_valid    <= 1'b0;
    end else if (i_load) begin
      r_shreg    <= i_load_data;
      r_byte_cnt <= '0;
      r_valid    <= 1'b1;
    end else if (w_fire) begin
      r_shreg <= r_shreg >> 8;
      if (w_last) begin
        r_byte_cnt <= '0;
        r_valid    <= 1'b0;
      end else begin
        r_byte_cnt <= r_byte_cnt + CNT_W'(1);
      end
    end
  end

  assign o_byte      = r_shreg[7:0];
  assign o_valid     = r_valid;
  assign o_word_done = w_fire & w_last;

endmodule

// File: rtl/latch_dump_sequencer.sv
// Walks the pipeline-latch debug mux through every select code in the table,
// captures each registered readback word and streams SYNC followed by all
// words (4 bytes each, LSB first) to the UART transmitter.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : dump request, honoured only in IDLE
//   mux_sel / mux_data  : debug mux select out, registered word back
//   tx_data / tx_valid  : byte stream to UART TX, accepted on tx_ready
//   busy / done         : dump in progress / one-cycle end-of-frame pulse
//   dbg_state           : current FSM state (dump_state_t encoding)
module latch_dump_sequencer
  import debug_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SEL_W   = 7,
  parameter int MUX_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [SEL_W-1:0]  mux_sel,
  input  logic [DATA_W-1:0] mux_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state
);

  localparam int IDX_W  = $clog2(N_WORDS);
  localparam int WAIT_W = $clog2(MUX_LAT + 1);

  dump_state_t       r_state;
  dump_state_t       w_next;
  logic [IDX_W-1:0]  r_idx;
  logic [WAIT_W-1:0] r_wait;
  logic [WAIT_W-1:0] w_wait_dec;
  logic [SEL_W-1:0]  r_mux_sel;
  logic              r_busy;
  logic              w_load;
  logic              w_last_word;
  logic [7:0]        w_ser_byte;
  logic              w_ser_valid;
  logic              w_word_done;

  assign w_wait_dec  = r_wait - WAIT_W'(1);
  assign w_last_word = (r_idx == IDX_W'(N_WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      ST_IDLE:    if (start) w_next = ST_SYNC_TX;
      ST_SYNC_TX: if (tx_ready) w_next = ST_SEL;
      ST_SEL:     w_next = ST_WAIT;
      // WAIT lasts MUX_LAT cycles, so CAP samples MUX_LAT+1 edges after sel.
      ST_WAIT:    if (w_wait_dec == '0) w_next = ST_CAP;
      ST_CAP: begin
        w_load = 1'b1;
        w_next = ST_SEND;
      end
      ST_SEND:    if (w_word_done) w_next = w_last_word ? ST_DONE : ST_SEL;
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_wait    <= '0;
      r_mux_sel <= '0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (start) begin
          r_busy <= 1'b1;
          r_idx  <= '0;
        end
        ST_SEL: begin
          r_mux_sel <= SEL_W'(sel_lookup(32'(r_idx)));
          r_wait    <= WAIT_W'(MUX_LAT);
        end
        ST_WAIT: r_wait <= w_wait_dec;
        ST_SEND: if (w_word_done && !w_last_word) r_idx <= r_idx + IDX_W'(1);
        ST_DONE: begin
          r_busy    <= 1'b0;
          r_mux_sel <= '0;
        end
        default: ;
      endcase
    end
  end

  word_serializer #(.DATA_W(DATA_W)) u_ser (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_load),
    .i_load_data (mux_data),
    .i_ready     (tx_ready),
    .o_byte      (w_ser_byte),
    .o_valid     (w_ser_valid),
    .o_word_done (w_word_done)
  );

  assign tx_valid  = (r_state == ST_SYNC_TX) | w_ser_valid;
  assign tx_data   = (r_state == ST_SYNC_TX) ? SYNC : w_ser_byte;
  assign mux_sel   = r_mux_sel;
  assign busy      = r_busy;
  assign done      = (r_state == ST_DONE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_latch_dump_sequencer.sv
module tb_latch_dump_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // DUT A: MUX_LAT=1, DUT B: MUX_LAT=2
  logic        start_a, tx_ready_a = 1'b0, tx_valid_a, busy_a, done_a;
  logic [6:0]  mux_sel_a;
  logic [31:0] mux_data_a;
  logic [7:0]  tx_data_a;
  logic [2:0]  dbg_a;
  logic        start_b, tx_ready_b = 1'b0, tx_valid_b, busy_b, done_b;
  logic [6:0]  mux_sel_b;
  logic [31:0] mux_data_b, mux_pipe_b;
  logic [7:0]  tx_data_b;
  logic [2:0]  dbg_b;

  latch_dump_sequencer #(.DATA_W(32), .SEL_W(7), .MUX_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .mux_sel(mux_sel_a), .mux_data(mux_data_a),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .busy(busy_a), .done(done_a), .dbg_state(dbg_a));

  latch_dump_sequencer #(.DATA_W(32), .SEL_W(7), .MUX_LAT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .mux_sel(mux_sel_b), .mux_data(mux_data_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .busy(busy_b), .done(done_b), .dbg_state(dbg_b));

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- debug mux models ----------------
  int         pat_mode = 0;
  logic [8:0] salt = '0;

  function automatic logic [31:0] mux_fn(input logic [6:0] sel);
    if (pat_mode == 0) return {sel, 25'h0};
    return {sel, 1'b1, ~sel, 1'b0, sel, salt};
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) mux_data_a <= '0;
    else        mux_data_a <= mux_fn(mux_sel_a);

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mux_pipe_b <= '0;
      mux_data_b <= '0;
    end else begin
      mux_pipe_b <= mux_fn(mux_sel_b);
      mux_data_b <= mux_pipe_b;
    end

  // ---------------- tx_ready drivers ----------------
  int ready_mode_a = 0;   // 0: always ready, 1: random, 2: random + 50-cycle stall
  int stall_left = 0;
  bit stall_done = 0;
  logic [7:0] rx_a[$];
  logic [7:0] rx_b[$];

  always @(posedge clk) begin
    #1;
    if (ready_mode_a != 2) stall_done = 0;
    case (ready_mode_a)
      0: tx_ready_a = 1'b1;
      1: tx_ready_a = ($urandom_range(0, 2) != 0);
      default: begin
        if (!stall_done && rx_a.size() % 77 == 10) begin
          stall_left = 50;
          stall_done = 1;
        end
        if (stall_left > 0) begin
          stall_left--;
          tx_ready_a = 1'b0;
        end else tx_ready_a = ($urandom_range(0, 1) == 1);
      end
    endcase
  end

  always @(posedge clk) begin
    #1;
    tx_ready_b = ($urandom_range(0, 3) != 0);
  end

  // ---------------- monitors (sample on negedge) ----------------
  int         done_cnt_a = 0, done_cnt_b = 0;
  bit         pend_a = 0;
  logic [7:0] pend_data_a;
  int         gap_a = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend_a = 0;
      gap_a = 0;
    end else begin
      if (pend_a) begin
        check("hold_valid", 32'(tx_valid_a), 32'd1);
        check("hold_data", 32'(tx_data_a), 32'(pend_data_a));
      end
      if (tx_valid_a && gap_a > 0) check("word_gap_ge3", 32'(gap_a >= 3), 32'd1);
      gap_a = (busy_a && !tx_valid_a) ? gap_a + 1 : 0;
      if (busy_a) check("sel_not_22", 32'(mux_sel_a != 7'h22), 32'd1);
      if (tx_valid_a && tx_ready_a) rx_a.push_back(tx_data_a);
      pend_a = tx_valid_a && !tx_ready_a;
      pend_data_a = tx_data_a;
      if (done_a) done_cnt_a++;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_valid_b && tx_ready_b) rx_b.push_back(tx_data_b);
      if (done_b) done_cnt_b++;
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] exp_q[$];

  // SYNC, then every table word as 4 bytes LSB first. Table: 00,01,10-15,20-25 minus 22,30-33,40,41.
  task automatic build_frame();
    int n;
    logic [6:0] sel;
    logic [31:0] d;
    exp_q.push_back(8'hA5);
    for (int g = 0; g < 5; g++) begin
      n = (g == 0) ? 2 : (g == 1) ? 6 : (g == 2) ? 6 : (g == 3) ? 4 : 2;
      for (int i = 0; i < n; i++) begin
        sel = 7'(g * 16 + i);
        if (sel == 7'h22) continue;
        d = mux_fn(sel);
        for (int b = 0; b < 4; b++) exp_q.push_back(d[8*b +: 8]);
      end
    end
  endtask

  task automatic compare_stream(input string tag, input bit use_b, input int base);
    int n;
    logic [7:0] got;
    n = (use_b ? rx_b.size() : rx_a.size()) - base;
    check({tag, "_len"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      got = 8'hxx;
      if (i < n) got = use_b ? rx_b[base + i] : rx_a[base + i];
      check(tag, 32'(got), 32'(exp_q[i]));
    end
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start_a();
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
  endtask

  task automatic wait_done_a(input string tag, input int limit);
    bit ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done_a) begin ok = 1; break; end
    end
    check({tag, "_done_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_rx_a(input string tag, input int count, input int limit);
    bit ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (rx_a.size() >= count) begin ok = 1; break; end
    end
    check({tag, "_rx_reached"}, 32'(ok), 32'd1);
  endtask

  // Waits for done, then checks the busy/done/mux_sel tail and the byte stream.
  task automatic finish_frame_a(input string tag, input int base, input int d0);
    wait_done_a(tag, 3000);
    check({tag, "_busy_at_done"}, 32'(busy_a), 32'd1);
    @(negedge clk);
    check({tag, "_busy_after"}, 32'(busy_a), 32'd0);
    check({tag, "_done_1cyc"}, 32'(done_a), 32'd0);
    check({tag, "_sel_zero"}, 32'(mux_sel_a), 32'd0);
    check({tag, "_valid_off"}, 32'(tx_valid_a), 32'd0);
    repeat (4) @(negedge clk);
    check({tag, "_done_count"}, 32'(done_cnt_a - d0), 32'd1);
    compare_stream(tag, 1'b0, base);
  endtask

  int base, d0;
  bit ok_b;

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    // 1: reset values
    #3;
    check("rst_valid", 32'(tx_valid_a), 32'd0);
    check("rst_data", 32'(tx_data_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_sel", 32'(mux_sel_a), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_valid", 32'(tx_valid_a), 32'd0);
    check("idle_busy", 32'(busy_a), 32'd0);

    // 2: full dump, always ready, {sel,25'h0} pattern
    pat_mode = 0; ready_mode_a = 0;
    base = rx_a.size(); d0 = done_cnt_a; build_frame();
    pulse_start_a();
    finish_frame_a("full", base, d0);

    // 3: same frame under random backpressure with a 50-cycle stall mid-word
    ready_mode_a = 2;
    base = rx_a.size(); d0 = done_cnt_a; build_frame();
    pulse_start_a();
    finish_frame_a("bp", base, d0);

    // 4: start during word 7 is ignored; a later start gives a second frame
    pat_mode = 1; salt = 9'($urandom); ready_mode_a = 1;
    base = rx_a.size(); d0 = done_cnt_a; build_frame();
    pulse_start_a();
    wait_rx_a("mid_start", base + 1 + 7 * 4 + 2, 2000);
    pulse_start_a();
    finish_frame_a("ign_start", base, d0);
    repeat (5) @(negedge clk);
    check("no_queued_start", 32'(rx_a.size() - base), 32'd77);
    salt = 9'($urandom);
    base = rx_a.size(); d0 = done_cnt_a; build_frame();
    pulse_start_a();
    finish_frame_a("second", base, d0);

    // 4b: start held high across DONE restarts on the first IDLE cycle
    base = rx_a.size(); d0 = done_cnt_a; build_frame(); build_frame();
    @(posedge clk); #1 start_a = 1'b1;
    wait_done_a("held1", 3000);
    @(negedge clk);
    @(posedge clk); #1 start_a = 1'b0;
    wait_done_a("held2", 3000);
    repeat (3) @(negedge clk);
    check("held_done_count", 32'(done_cnt_a - d0), 32'd2);
    compare_stream("held", 1'b0, base);

    // 5: reset after byte 30, then a clean restart
    salt = 9'($urandom);
    base = rx_a.size();
    pulse_start_a();
    wait_rx_a("pre_rst", base + 30, 2000);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(tx_valid_a), 32'd0);
    check("midrst_busy", 32'(busy_a), 32'd0);
    check("midrst_sel", 32'(mux_sel_a), 32'd0);
    check("midrst_data", 32'(tx_data_a), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("postrst_valid", 32'(tx_valid_a), 32'd0);
    base = rx_a.size(); d0 = done_cnt_a; build_frame();
    pulse_start_a();
    finish_frame_a("restart", base, d0);

    // 6: MUX_LAT=2 instance, unique per-select data
    salt = 9'($urandom);
    base = rx_b.size(); d0 = done_cnt_b; build_frame();
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    ok_b = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done_b) begin ok_b = 1; break; end
    end
    check("lat2_done_seen", 32'(ok_b), 32'd1);
    repeat (4) @(negedge clk);
    check("lat2_busy_after", 32'(busy_b), 32'd0);
    check("lat2_done_count", 32'(done_cnt_b - d0), 32'd1);
    compare_stream("lat2", 1'b1, base);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
